alu_issue_buffer: RTL and testbench



---
 rtl/alu_issue_buffer.sv | 145 ++++++++++++++
 tb/tb_alu_issue_buffer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_buffer.sv
// Valid/ready FIFO request buffer feeding the 32-bit ALU; drops and counts illegal function codes.
// Optional same-cycle empty-buffer bypass is enabled by defining ALU_ISSUE_BYPASS_EN.
module alu_issue_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_dataA,
    input  logic [WIDTH-1:0]         in_dataB,
    input  logic [5:0]               in_Signal,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         dataA,
    output logic [WIDTH-1:0]         dataB,
    output logic [5:0]               Signal,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     illegal_op,
    output logic [CNT_W-1:0]         illegal_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned SIG_W = 6;
    localparam int unsigned ENT_W = 2 * WIDTH + SIG_W;

    localparam logic [SIG_W-1:0] OP_AND = 6'b100100;
    localparam logic [SIG_W-1:0] OP_OR  = 6'b100101;
    localparam logic [SIG_W-1:0] OP_ADD = 6'b100000;
    localparam logic [SIG_W-1:0] OP_SUB = 6'b100010;
    localparam logic [SIG_W-1:0] OP_SLT = 6'b101010;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic             illegal_op_q, illegal_op_d;
    logic [CNT_W-1:0] illegal_count_q, illegal_count_d;

    logic             legal_c;
    logic             empty_c;
    logic             accept_c;
    logic             bypass_c;
    logic             push_c;
    logic             drop_c;
    logic             pop_c;
    logic [ENT_W-1:0] head_c;

    function automatic logic is_legal(input logic [SIG_W-1:0] sig);
        logic ok;
        ok = 1'b0;
        case (sig)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: ok = 1'b1;
            default:                               ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Handshake decode; in_ready comes only from registered occupancy.
    always_comb begin
        legal_c  = is_legal(in_Signal);
        empty_c  = (count_q == '0);
        accept_c = in_valid && in_ready;
`ifdef ALU_ISSUE_BYPASS_EN
        bypass_c = empty_c && in_valid && legal_c && out_ready;
`else
        bypass_c = 1'b0;
`endif
        push_c   = accept_c && legal_c && !bypass_c;
        drop_c   = accept_c && !legal_c;
        pop_c    = !empty_c && out_ready;
        head_c   = mem_q[rd_ptr_q];
    end

    assign in_ready = (count_q != OCC_W'(DEPTH));

    always_comb begin
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;
        illegal_op_d    = drop_c;
        illegal_count_d = illegal_count_q;

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_c && !pop_c) begin
            count_d = count_q + OCC_W'(1);
        end else if (pop_c && !push_c) begin
            count_d = count_q - OCC_W'(1);
        end
        if (drop_c && (illegal_count_q != '1)) begin
            illegal_count_d = illegal_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            illegal_op_q    <= 1'b0;
            illegal_count_q <= '0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            illegal_op_q    <= illegal_op_d;
            illegal_count_q <= illegal_count_d;
        end
    end

    // Payload storage carries no reset; contents are only read when occupied.
    always_ff @(posedge clk) begin
        if (push_c && !reset) begin
            mem_q[wr_ptr_q] <= {in_dataA, in_dataB, in_Signal};
        end
    end

    // Idle outputs are forced to zero so the ALU never sees a stale function code.
    always_comb begin
        out_valid = !empty_c || bypass_c;
        dataA     = '0;
        dataB     = '0;
        Signal    = '0;
        if (!empty_c) begin
            {dataA, dataB, Signal} = head_c;
        end else if (bypass_c) begin
            dataA  = in_dataA;
            dataB  = in_dataB;
            Signal = in_Signal;
        end
    end

    assign count         = count_q;
    assign illegal_op    = illegal_op_q;
    assign illegal_count = illegal_count_q;

endmodule

// File: tb/tb_alu_issue_buffer.sv
// Directed + randomized bench for alu_issue_buffer, checked against a queue-based reference model.
// Set ALU_ISSUE_BYPASS_EN on both files to exercise the bypass path.
module tb_alu_issue_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;
`ifdef ALU_ISSUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [5:0]       s;
    } ent_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_dataA = '0;
    logic [WIDTH-1:0] in_dataB = '0;
    logic [5:0]       in_Signal = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic [5:0]       Signal;
    logic [OCC_W-1:0] count;
    logic             illegal_op;
    logic [CNT_W-1:0] illegal_count;

    int tests  = 0;
    int failed = 0;

    ent_t q[$];
    bit   m_ill_pulse = 1'b0;
    int   m_ill_cnt   = 0;

    logic [5:0] codes [5] = '{6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010};

    alu_issue_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dataA(in_dataA), .in_dataB(in_dataB), .in_Signal(in_Signal),
        .out_valid(out_valid), .out_ready(out_ready),
        .dataA(dataA), .dataB(dataB), .Signal(Signal),
        .count(count), .illegal_op(illegal_op), .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    function automatic bit legal(input logic [5:0] s);
        return (s == 6'b100100) || (s == 6'b100101) || (s == 6'b100000) ||
               (s == 6'b100010) || (s == 6'b101010);
    endfunction

    function automatic logic [5:0] rand_illegal();
        logic [5:0] s;
        s = 6'($urandom);
        while (legal(s)) s = 6'($urandom);
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check outputs against the model, then advance the model.
    task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] s, input logic r);
        bit   byp, acc, lg;
        ent_t head;
        bit   ev;
        @(negedge clk);
        in_valid = v; in_dataA = a; in_dataB = b; in_Signal = s; out_ready = r;
        #1;
        lg   = legal(s);
        acc  = v && (q.size() < DEPTH);
        byp  = BYP && (q.size() == 0) && v && lg && r;
        ev   = (q.size() > 0) || byp;
        head = '0;
        if (q.size() > 0) head = q[0];
        else if (byp) head = '{a: a, b: b, s: s};
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
        chk("count", 32'(count), 32'(q.size()));
        chk("dataA", dataA, head.a);
        chk("dataB", dataB, head.b);
        chk("Signal", 32'(Signal), 32'(head.s));
        chk("illegal_op", 32'(illegal_op), 32'(m_ill_pulse));
        chk("illegal_count", 32'(illegal_count), 32'(m_ill_cnt));
        if ((q.size() > 0) && r) void'(q.pop_front());
        if (acc && lg && !byp) q.push_back('{a: a, b: b, s: s});
        m_ill_pulse = acc && !lg;
        if (m_ill_pulse && (m_ill_cnt < (1 << CNT_W) - 1)) m_ill_cnt++;
    endtask

    task automatic idle(input logic r);
        cycle(1'b0, 32'h0, 32'h0, 6'h0, r);
    endtask

    // Reset is asserted alongside an active push/pop to show it takes priority.
    task automatic apply_reset(input int n);
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b1; in_Signal = 6'b100000; out_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        q.delete();
        m_ill_pulse = 1'b0;
        m_ill_cnt   = 0;
    endtask

    initial begin
        // Reset then idle.
        apply_reset(2);
        idle(1'b0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_signal", 32'(Signal), 32'd0);

        // Fill with out_ready low, try a fifth push, then drain in order.
        cycle(1'b1, 32'd5, 32'd3, 6'b100000, 1'b0);
        cycle(1'b1, 32'd9, 32'd4, 6'b100010, 1'b0);
        cycle(1'b1, 32'hF0, 32'h3C, 6'b100100, 1'b0);
        cycle(1'b1, 32'd1, 32'd2, 6'b100101, 1'b0);
        cycle(1'b1, 32'd77, 32'd88, 6'b100000, 1'b0);
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        chk("fill_head_a", dataA, 32'd5);
        chk("fill_head_s", 32'(Signal), 32'(6'b100000));
        repeat (4) idle(1'b1);
        idle(1'b1);
        chk("drain_count", 32'(count), 32'd0);

        // Illegal filter: the zero code is swallowed, the ADD is kept.
        cycle(1'b1, 32'd1, 32'd1, 6'b000000, 1'b0);
        cycle(1'b1, 32'd1, 32'd1, 6'b100000, 1'b0);
        chk("ill_pulse", 32'(illegal_op), 32'd1);
        idle(1'b0);
        chk("ill_pulse_end", 32'(illegal_op), 32'd0);
        chk("ill_count1", 32'(illegal_count), 32'd1);
        chk("ill_only_add", 32'(count), 32'd1);
        idle(1'b1);

        // Hold occupancy at 2 with simultaneous push/pop across many wraps.
        cycle(1'b1, $urandom, $urandom, codes[$urandom_range(0, 4)], 1'b0);
        cycle(1'b1, $urandom, $urandom, codes[$urandom_range(0, 4)], 1'b0);
        for (int i = 0; i < 10 * DEPTH; i++)
            cycle(1'b1, $urandom, $urandom, codes[$urandom_range(0, 4)], 1'b1);
        idle(1'b0);
        chk("wrap_count", 32'(count), 32'd2);
        repeat (3) idle(1'b1);

        // Counter saturation.
        for (int i = 0; i < 300; i++)
            cycle(1'b1, $urandom, $urandom, rand_illegal(), 1'b0);
        idle(1'b0);
        chk("sat_count", 32'(illegal_count), 32'd255);

        // Randomized traffic mixing legal, illegal, stalls and back-pressure.
        for (int i = 0; i < 600; i++) begin
            logic [5:0] s;
            s = ($urandom_range(0, 3) != 0) ? codes[$urandom_range(0, 4)] : 6'($urandom);
            cycle(1'($urandom_range(0, 1)), $urandom, $urandom, s, 1'($urandom_range(0, 2) == 0));
        end

        // Reset in the middle of operation.
        apply_reset(1);
        idle(1'b0);
        cycle(1'b1, 32'd11, 32'd12, 6'b100000, 1'b0);
        cycle(1'b1, 32'd13, 32'd14, 6'b100010, 1'b0);
        cycle(1'b1, 32'd15, 32'd16, 6'b101010, 1'b0);
        idle(1'b0);
        chk("mid_count3", 32'(count), 32'd3);
        apply_reset(1);
        idle(1'b0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);

        // Empty-buffer SLT with out_ready high: bypassed only when the feature is built in.
        cycle(1'b1, 32'd2, 32'd7, 6'b101010, 1'b1);
`ifdef ALU_ISSUE_BYPASS_EN
        chk("byp_valid", 32'(out_valid), 32'd1);
        chk("byp_signal", 32'(Signal), 32'(6'b101010));
        chk("byp_count", 32'(count), 32'd0);
        idle(1'b0);
        chk("byp_after", 32'(count), 32'd0);
`else
        chk("nobyp_valid", 32'(out_valid), 32'd0);
        idle(1'b0);
        chk("nobyp_after", 32'(count), 32'd1);
`endif
        repeat (2) idle(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
